// File: rtl/bram_burst_read_streamer.sv
// Burst read sequencer for a simple-dual-port BRAM read port: issues sequential reads under FIFO
// credit, tracks them through the RAM read pipeline and streams them out of an FWFT skid FIFO.
module bram_burst_read_streamer #(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_ADDR_WIDTH = 9,
   parameter int C_LEN_WIDTH  = 10,
   parameter int C_RD_LATENCY = 1,
   parameter int C_FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [C_ADDR_WIDTH-1:0] start_addr,
   input  logic [C_LEN_WIDTH-1:0]  xfer_len,
   output logic                    busy,
   output logic                    done,
   output logic [C_ADDR_WIDTH-1:0] rdAddr,
   output logic                    rden,
   input  logic [C_DATA_WIDTH-1:0] ram_dout,
   output logic                    m_valid,
   output logic [C_DATA_WIDTH-1:0] m_data,
   input  logic                    m_ready
);

   localparam int INF_W = $clog2(C_RD_LATENCY + 1) + 1;
   localparam int CNT_W = $clog2(C_FIFO_DEPTH) + 1;
   localparam int PTR_W = $clog2(C_FIFO_DEPTH);
   localparam logic [31:0]      DEPTH_U  = 32'(C_FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(C_FIFO_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [C_LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic [C_RD_LATENCY-1:0] tag_q, tag_d;
   logic [INF_W-1:0]        inflight_q, inflight_d;
   logic [CNT_W-1:0]        fifo_count_q, fifo_count_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                    done_q, done_d;
   logic [C_DATA_WIDTH-1:0] fifo_mem_q [C_FIFO_DEPTH];

   logic credit_ok, issue, push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // rden stays high outside IDLE so the RAM output pipeline keeps draining
   assign rden      = (state_q != S_IDLE);
   assign busy      = rden;
   assign done      = done_q;
   assign rdAddr    = addr_q;
   assign m_valid   = (fifo_count_q != '0);
   assign m_data    = fifo_mem_q[rd_ptr_q];
   assign pop       = m_valid && m_ready;
   assign push      = rden && tag_q[C_RD_LATENCY-1];

   // Words already in the FIFO plus words in the RAM pipe must fit; a same-cycle pop earns no credit
   assign credit_ok = (32'(fifo_count_q) + 32'(inflight_q)) < DEPTH_U;
   assign issue     = (state_q == S_ISSUE) && (remaining_q != '0) && credit_ok;

   always_comb begin
      tag_d = tag_q;
      if (rden) begin
         tag_d[0] = issue;
         for (int i = 1; i < C_RD_LATENCY; i++) tag_d[i] = tag_q[i-1];
      end
      inflight_d   = inflight_q + INF_W'(issue) - INF_W'(push);
      fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (xfer_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = S_ISSUE;
                  addr_d      = start_addr;
                  remaining_d = xfer_len;
               end
            end
         end
         S_ISSUE: begin
            if (issue) begin
               addr_d      = addr_q + C_ADDR_WIDTH'(1);
               remaining_d = remaining_q - C_LEN_WIDTH'(1);
               if (remaining_q == C_LEN_WIDTH'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (inflight_q == '0 && fifo_count_d == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         remaining_q  <= '0;
         tag_q        <= '0;
         inflight_q   <= '0;
         fifo_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         tag_q        <= tag_d;
         inflight_q   <= inflight_d;
         fifo_count_q <= fifo_count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         done_q       <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= ram_dout;
   end

endmodule
